mdu_hilo: RTL and testbench

Iterative multiply/divide unit that consumes the two register-file read operands (qa, qb) and owns the HI/LO result pair for MIPS mult/multu/div/divu/mthi/mtlo/mfhi/mflo. It sits directly downstream of the register file, in parallel with the ALU. It raises busy so the control unit can stall issue of any instruction that touches HI/LO. HI/LO outputs feed the writeback mux for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/mdu_sign_fix.sv | 12 +
 rtl/mdu_hilo.sv | 178 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, state type, default width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: takes |x| on operand entry and restores sign on results.
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO for mult/multu/div/divu/mthi/mtlo.
// Define MDU_FAST_MUL_EN for single-cycle combinational multiplies (divides stay iterative).
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed, op_div, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign sa        = op_signed & a[WIDTH-1];
    assign sb        = op_signed & b[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.din(a), .neg(sa), .dout(abs_a));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.din(b), .neg(sb), .dout(abs_b));

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt;
    assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    logic [WIDTH:0]     rsh, trial;
    logic               qbit;
    logic [2*WIDTH-1:0] div_nxt, acc_nxt;
    assign rsh     = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial   = rsh - {1'b0, opnd_q};
    assign qbit    = ~trial[WIDTH];
    assign div_nxt = {(qbit ? trial[WIDTH-1:0] : rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
    assign acc_nxt = div_q ? div_nxt : mul_nxt;

    logic [2*WIDTH-1:0] prod_in, prod_res;
    logic               prod_neg;
    logic [WIDTH-1:0]   quo_res, rem_res;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    assign prod_in   = (state_q == IDLE) ? fast_prod : acc_nxt;
    assign prod_neg  = (state_q == IDLE) ? (sa ^ sb) : neg_q;
`else
    assign prod_in   = acc_nxt;
    assign prod_neg  = neg_q;
`endif

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.din(prod_in), .neg(prod_neg), .dout(prod_res));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .din(acc_nxt[WIDTH-1:0]), .neg(neg_q), .dout(quo_res)
    );
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .din(acc_nxt[2*WIDTH-1:WIDTH]), .neg(rneg_q), .dout(rem_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
`ifdef MDU_FAST_MUL_EN
                            if (!op_div) begin
                                hi_d   = prod_res[2*WIDTH-1:WIDTH];
                                lo_d   = prod_res[WIDTH-1:0];
                                done_d = 1'b1;
                            end else begin
`else
                            begin
`endif
                                opnd_d  = op_div ? abs_b : abs_a;
                                acc_d   = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                                div_d   = op_div;
                                neg_d   = sa ^ sb;
                                rneg_d  = sa;
                                dz_d    = (b == '0);
                                cnt_d   = '0;
                                state_d = RUN;
                            end
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (div_q) begin
                        // Zero divisor leaves |a| as remainder; quotient is forced to all-ones.
                        hi_d = rem_res;
                        lo_d = dz_q ? '1 : quo_res;
                    end else begin
                        hi_d = prod_res[2*WIDTH-1:WIDTH];
                        lo_d = prod_res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] ux, uy;
        longint      p;
        int          sx, sy, q, r;
        ux = {32'h0, x};
        uy = {32'h0, y};
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd0: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            3'd3: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int nbusy);
        int cyc;
        cyc   = 0;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done"}, {63'h0, done}, 64'h1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [63:0] exp;
        int          nb;
        exp = ref_model(o, x, y);
        issue(o, x, y);
        wait_done(tag, nb);
        check({tag, "_busycyc"}, 64'(nb), 64'(W));
        check({tag, "_hilo"}, {hi, lo}, exp);
        @(posedge clk);
        #1;
        check({tag, "_doneoff"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int          nb, seen;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [63:0] exp;

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check("reset", {busy, done, hi, lo}, 66'h0);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 3'd3, 32'd100, 32'd0);
        run_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        issue(3'd4, 32'h1234_5678, 32'h0);
        check("mthi", {busy, done, hi}, {2'b00, 32'h1234_5678});
        issue(3'd5, 32'hCAFE_0001, 32'h0);
        check("mtlo", {busy, done, lo}, {2'b00, 32'hCAFE_0001});

        // MTLO and MTHI during a divide must be dropped.
        issue(3'd2, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        issue(3'd4, 32'hDEAD_BEEF, 32'h0);
        check("hold_mid", {busy, lo}, {1'b1, 32'hCAFE_0001});
        wait_done("mtlo_busy", nb);
        check("mtlo_busy_hilo", {hi, lo}, {32'd2, 32'd14});

        // Back-to-back: second start lands in the done cycle.
        issue(3'd1, 32'd1000, 32'd3);
        wait_done("b2b1", nb);
        check("b2b1_hilo", {hi, lo}, ref_model(3'd1, 32'd1000, 32'd3));
        issue(3'd3, 32'd1000, 32'd3);
        wait_done("b2b2", nb);
        check("b2b2_busycyc", 64'(nb), 64'(W));
        check("b2b2_hilo", {hi, lo}, ref_model(3'd3, 32'd1000, 32'd3));

        // Abort at iteration 10.
        issue(3'd1, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("abort", {busy, done, hi, lo}, 66'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_nodone", 64'(seen), 64'h0);
        run_op("multu_5x6", 3'd1, 32'd5, 32'd6);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) ry = -ry;
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            exp = ref_model(ro, rx, ry);
            issue(ro, rx, ry);
            wait_done("rnd", nb);
            check($sformatf("rnd%0d_op%0d_busycyc", i, ro), 64'(nb), 64'(W));
            check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, rx, ry), {hi, lo}, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
